// File: rtl/mux_bus_arbiter_if.sv
// Bundles the handshake and bus signals of the mux_bus_arbiter.
//   master : arbiter side. Inputs are requests, addresses and memReady.
//            Outputs are grants, select, memory address/valid, done and err.
//   slave  : requesters/memory side, the mirror of master.
interface mux_bus_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              reqA;
  logic              reqB;
  logic [DATA_W-1:0] addrA;
  logic [DATA_W-1:0] addrB;
  logic              memReady;
  logic              memValid;
  logic [DATA_W-1:0] memAddr;
  logic              select;
  logic              gntA;
  logic              gntB;
  logic              doneA;
  logic              doneB;
  logic              err;

  modport master (
    input  reqA, reqB, addrA, addrB, memReady,
    output memValid, memAddr, select, gntA, gntB, doneA, doneB, err
  );

  modport slave (
    output reqA, reqB, addrA, addrB, memReady,
    input  memValid, memAddr, select, gntA, gntB, doneA, doneB, err
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// A (fetch) and B (load/store) compete for the port. The winner's address is
// captured into memAddr, and the grant is held until memory returns memReady.
// Every output is registered.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mux_bus_arbiter_if.master (reqA/B, addrA/B, memReady in;
//         memValid, memAddr, select, gntA/B, doneA/B, err out)
// Optional build macro MUX_ARB_TIMEOUT_EN adds a grant timeout. The timeout
// aborts the access after TIMEOUT_CYCLES grant cycles and pulses err with done.
// Without the macro, err is tied to 0.
module mux_bus_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux_bus_arbiter_if.master bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mux_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              mem_valid_q, mem_valid_d;
  logic              select_q, select_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic              done_a_q, done_a_d;
  logic              done_b_q, done_b_d;
  logic              last_b_q, last_b_d;   // 1 = B won the last access
  logic              elig_a_c, elig_b_c;
  logic              expired_c;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  // Limit cycle: the grant has already run TIMEOUT_CYCLES-1 cycles.
  assign expired_c = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign expired_c = 1'b0;
`endif

  // A requester that is still seeing its done pulse has not dropped req yet.
  // It must not be re-granted.
  assign elig_a_c = bus.reqA & ~done_a_q;
  assign elig_b_c = bus.reqB & ~done_b_q;

  // Next state and next output values.
  always_comb begin
    state_d     = state_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    mem_valid_d = mem_valid_q;
    select_d    = select_q;
    mem_addr_d  = mem_addr_q;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    last_b_d    = last_b_q;

    unique case (state_q)
      IDLE: begin
        // Round-robin tie break: the requester opposite the last winner wins.
        if (elig_a_c && (!elig_b_c || last_b_q)) begin
          state_d     = GRANT_A;
          gnt_a_d     = 1'b1;
          mem_valid_d = 1'b1;
          select_d    = 1'b0;
          mem_addr_d  = bus.addrA;
        end else if (elig_b_c) begin
          state_d     = GRANT_B;
          gnt_b_d     = 1'b1;
          mem_valid_d = 1'b1;
          select_d    = 1'b1;
          mem_addr_d  = bus.addrB;
        end
      end
      GRANT_A: begin
        if (bus.memReady || expired_c) begin
          state_d     = IDLE;
          gnt_a_d     = 1'b0;
          mem_valid_d = 1'b0;
          done_a_d    = 1'b1;
          last_b_d    = 1'b0;
        end
      end
      GRANT_B: begin
        if (bus.memReady || expired_c) begin
          state_d     = IDLE;
          gnt_b_d     = 1'b0;
          mem_valid_d = 1'b0;
          done_b_d    = 1'b1;
          last_b_d    = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        mem_valid_d = 1'b0;
      end
    endcase

`ifdef MUX_ARB_TIMEOUT_EN
    // Timer restarts on grant entry and counts grant cycles without memReady.
    timer_d = timer_q;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      timer_d = '0;
    end else if (!bus.memReady) begin
      if (expired_c) begin
        err_d = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      select_q    <= 1'b0;
      mem_addr_q  <= '0;
      done_a_q    <= 1'b0;
      done_b_q    <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      mem_valid_q <= mem_valid_d;
      select_q    <= select_d;
      mem_addr_q  <= mem_addr_d;
      done_a_q    <= done_a_d;
      done_b_q    <= done_b_d;
      last_b_q    <= last_b_d;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  // Timeout timer and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.gntA     = gnt_a_q;
  assign bus.gntB     = gnt_b_q;
  assign bus.memValid = mem_valid_q;
  assign bus.select   = select_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.doneA    = done_a_q;
  assign bus.doneB    = done_b_q;

endmodule
